// File: rtl/rt_pkg.sv
// Shared types for the ray-tracer result path: 16.16 fixed-point type, hit record
// layout, writer FSM states and the halfword selector used on the SDRAM bus.
package rt_pkg;

    typedef logic signed [31:0] fip;

    localparam fip FIP_MAX       = 32'sh7FFF_FFFF;
    localparam int RECORD_BYTES  = 12;
    localparam int RECORD_HWORDS = 6;

    typedef struct packed {
        logic [31:0] ray_index;
        logic        hit;
        fip          t;
        logic [31:0] tri_index;
    } record_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE
    } state_t;

    // Memory image is {hit word, t, tri_index}, each word sent low halfword first.
    function automatic logic [15:0] record_hword(input record_t rec, input logic [2:0] k);
        logic [15:0] hw;
        case (k)
            3'd0:    hw = {15'b0, rec.hit};
            3'd1:    hw = 16'h0000;
            3'd2:    hw = rec.t[15:0];
            3'd3:    hw = rec.t[31:16];
            3'd4:    hw = rec.tri_index[15:0];
            3'd5:    hw = rec.tri_index[31:16];
            default: hw = 16'h0000;
        endcase
        return hw;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; DEPTH must be a power of two.
// Read data is the head entry, available combinationally while not empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hit_writer.sv
// Buffers per-ray hit results and writes each as six 16-bit halfwords to SDRAM.
// Build option HIT_WRITER_MISS_SKIP_EN: records with hit = 0 are counted but not written.
//
// state    | meaning
// ST_IDLE  | waiting for a buffered record
// ST_LOAD  | pop FIFO head into the record register, k = 0
// ST_WRITE | drive halfword k until accepted; leave after k = 5
module hit_writer
    import rt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        baseaddr,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [31:0]        i_ray_index,
    input  logic               i_hit,
    input  logic signed [31:0] i_t,
    input  logic [31:0]        i_tri_index,
    output logic               avm_m0_write,
    output logic [31:0]        avm_m0_address,
    output logic [15:0]        avm_m0_writedata,
    output logic [1:0]         avm_m0_byteenable,
    input  logic               avm_m0_waitrequest,
    output logic               o_idle,
    output logic [31:0]        o_wr_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    record_t       in_rec;
    record_t       head;
    record_t       rec;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] fill;
    logic          run;
    state_t        state;
    state_t        state_nxt;
    logic [2:0]    k;
    logic          hw_acc;
    logic          last_hw;
    logic          skip;
    logic          rec_done;

    assign in_rec = '{ray_index: i_ray_index, hit: i_hit, t: i_t, tri_index: i_tri_index};

    // run holds ready low for the first cycle after reset is released
    assign o_ready = run && !full;
    assign push    = i_valid && o_ready;
    assign pop     = (state == ST_LOAD);

    sync_fifo #(
        .WIDTH($bits(record_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (in_rec),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fill)
    );

    assign hw_acc  = (state == ST_WRITE) && !avm_m0_waitrequest;
    assign last_hw = (k == 3'(RECORD_HWORDS - 1));

`ifdef HIT_WRITER_MISS_SKIP_EN
    assign skip = (state == ST_LOAD) && !head.hit;
`else
    assign skip = 1'b0;
`endif

    assign rec_done = (hw_acc && last_hw) || skip;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!empty) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = skip ? ST_IDLE : ST_WRITE;
            ST_WRITE: if (hw_acc && last_hw) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rec        <= '0;
            k          <= 3'd0;
            o_wr_count <= 32'd0;
            run        <= 1'b0;
        end else begin
            run <= 1'b1;
            if (pop) begin
                rec <= head;
                k   <= 3'd0;
            end else if (hw_acc) begin
                k <= k + 3'd1;
            end
            if (rec_done) begin
                o_wr_count <= o_wr_count + 32'd1;
            end
        end
    end

    // Bus outputs are forced to zero outside WRITE so reset and idle values are defined.
    always_comb begin
        avm_m0_write      = (state == ST_WRITE);
        avm_m0_byteenable = 2'b00;
        avm_m0_address    = 32'd0;
        avm_m0_writedata  = 16'd0;
        if (avm_m0_write) begin
            avm_m0_byteenable = 2'b11;
            avm_m0_address    = baseaddr + rec.ray_index * 32'(RECORD_BYTES) + {28'd0, k, 1'b0};
            avm_m0_writedata  = record_hword(rec, k);
        end
    end

    assign o_idle = (fill == '0) && (state == ST_IDLE);

endmodule
